// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier controller: steps an external width-bit
// adder once per cycle to form an unsigned 2*width-bit product.
module mult_seq_ctrl #(
   parameter int width = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [width-1:0]     a_i,
   input  logic [width-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*width-1:0]   p_o,
   output logic [width-1:0]     add_a_o,
   output logic [width-1:0]     add_b_o,
   input  logic [width:0]       add_s_i
);

   localparam int CW = $clog2(width + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(width - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [width-1:0]   m_q, m_d;
   logic [width-1:0]   q_q, q_d;
   logic [width-1:0]   a_q, a_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*width-1:0] p_q, p_d;

   // Handshake: start_i is a request sampled only while idle (busy_o low);
   // busy_o stays high from the cycle after acceptance through the done_o
   // cycle, and done_o pulses once with p_o already holding the new product.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      add_a_o = '0;
      add_b_o = '0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               m_d     = a_i;
               q_d     = b_i;
               a_d     = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            add_a_o = a_q;
            add_b_o = q_q[0] ? m_q : '0;
            // Adder carry lands in A's MSB; the sum LSB shifts into Q.
            a_d     = add_s_i[width:1];
            q_d     = {add_s_i[0], q_q[width-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               // Load the product on the final step so it is valid during DONE.
               p_d     = {add_s_i[width:1], add_s_i[0], q_q[width-1:1]};
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         q_q     <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);
   assign p_o    = p_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: width-8 and width-4 instances, each with a
// behavioural adder, checked against plain integer multiplication.
module tb_mult_seq_ctrl;

   logic        clk;
   logic        rst_n;

   logic        start8, busy8, done8;
   logic [7:0]  a8, b8, add_a8, add_b8;
   logic [8:0]  add_s8;
   logic [15:0] p8;

   logic        start4, busy4, done4;
   logic [3:0]  a4, b4, add_a4, add_b4;
   logic [4:0]  add_s4;
   logic [7:0]  p4;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-ins for the external full_adder_nbits instances.
   assign add_s8 = {1'b0, add_a8} + {1'b0, add_b8};
   assign add_s4 = {1'b0, add_a4} + {1'b0, add_b4};

   mult_seq_ctrl #(.width(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
      .busy_o(busy8), .done_o(done8), .p_o(p8),
      .add_a_o(add_a8), .add_b_o(add_b8), .add_s_i(add_s8)
   );

   mult_seq_ctrl #(.width(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
      .busy_o(busy4), .done_o(done4), .p_o(p4),
      .add_a_o(add_a4), .add_b_o(add_b4), .add_s_i(add_s4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One width-8 multiplication; optionally pokes start mid-run or resets at RUN cycle 4.
   task automatic run8(input int a, input int b, input bit interfere, input bit rst_mid);
      int n, busy_n, lat;
      bit got;
      logic [31:0] exp_p;
      exp_q.push_back(32'(a * b));
      @(negedge clk);
      a8 = 8'(a); b8 = 8'(b); start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0; busy_n = 0; got = 1'b0; lat = 0;
      while (!got && n < 30) begin
         n++;
         busy_n += int'(busy8);
         if (done8) begin
            got = 1'b1;
            lat = n;
         end else if (n <= 8) begin
            check_eq("add_b", 32'(add_b8), (((b >> (n - 1)) & 1) != 0) ? 32'(a) : 32'd0);
            check_eq("add_a", 32'(add_a8), 32'((a * (b & ((1 << (n - 1)) - 1))) >> (n - 1)));
         end
         if (rst_mid && n == 4) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_busy", 32'(busy8), 32'd0);
            check_eq("rst_done", 32'(done8), 32'd0);
            check_eq("rst_p", 32'(p8), 32'd0);
            void'(exp_q.pop_back());
            @(negedge clk);
            check_eq("rst_no_done", 32'(done8), 32'd0);
            rst_n = 1'b1;
            return;
         end
         if (interfere && n == 4) begin
            start8 = 1'b1; a8 = ~8'(a); b8 = 8'(b + 1);
         end
         if (interfere && n == 5) start8 = 1'b0;
         if (!got) @(negedge clk);
      end
      exp_p = exp_q.pop_front();
      check_eq("done_seen", 32'(got), 32'd1);
      check_eq("latency", 32'(lat), 32'd9);
      check_eq("busy_cycles", 32'(busy_n), 32'd9);
      check_eq("product", 32'(p8), exp_p);
      check_eq("done_add_a", 32'(add_a8), 32'd0);
      @(negedge clk);
      check_eq("done_pulse", 32'(done8), 32'd0);
      check_eq("busy_after", 32'(busy8), 32'd0);
      check_eq("p_held", 32'(p8), exp_p);
      repeat (12) begin
         @(negedge clk);
         if (done8) check_eq("extra_done", 32'(done8), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t1, t2;
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      #3;
      check_eq("reset_busy", 32'(busy8), 32'd0);
      check_eq("reset_done", 32'(done8), 32'd0);
      check_eq("reset_p", 32'(p8), 32'd0);
      check_eq("reset_add_b", 32'(add_b8), 32'd0);
      check_eq("reset_busy4", 32'(busy4), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run8(3, 5, 1'b0, 1'b0);
      run8(255, 255, 1'b0, 1'b0);
      run8(0, 200, 1'b0, 1'b0);
      run8(200, 0, 1'b0, 1'b0);
      run8(100, 55, 1'b1, 1'b0);
      run8(100, 77, 1'b0, 1'b1);
      run8(7, 9, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'b0);
      end

      // Width-4 instance with start held high across two operations.
      @(negedge clk);
      a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
      n = 0; t1 = -1; t2 = -1;
      while (t2 < 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (done4) begin
            if (t1 < 0) begin
               t1 = n;
               check_eq("w4_p1", 32'(p4), 32'd225);
               a4 = 4'd1; b4 = 4'd1;
            end else begin
               t2 = n;
               check_eq("w4_p2", 32'(p4), 32'd1);
               start4 = 1'b0;
            end
         end
      end
      check_eq("w4_latency", 32'(t1), 32'd5);
      check_eq("w4_interval", 32'(t2 - t1), 32'd6);
      @(negedge clk);
      check_eq("w4_done_pulse", 32'(done4), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
